inside_point_stats: RTL and testbench
=====================================

Name: inside_point_stats

Overview:
- Extension stage directly downstream of the distance filter in the per-frame extension chain.
- Reads every point of the frame together with the custom-field label the filter wrote: 2 = inside, 1 = outside.
- Accumulates per-frame statistics over the inside points only: count, per-axis signed min/max (bounding box) and per-axis sums.
- Publishes the results at end of frame through the EXT_doneProcessing handshake. The stage is read-only and writes no points.

Parameters:
- LABEL_INSIDE, 16'd2, custom-field value that marks a point as inside.
- SUM_W, 36, width of the signed per-axis sum accumulators (covers 2^19 points × 16-bit values).

Ports:
- i_SYSTEM_clk  in  1  system clock
- i_SYSTEM_rst  in  1  asynchronous active-low reset
- EXT_enable  in  1  start/continue processing
- EXT_PCSize  in  19  number of points in the frame
- EXT_readReady  out  1  stage requests a point
- EXT_readValid  in  1  point/custom field valid
- EXT_readID  out  19  index of the requested point
- EXT_readCustomField  in  16  label of the point being read
- EXT_pointX/Y/Z  in  16 each  signed point coordinates
- EXT_writeValid  out  1  tied 0 (read-only stage)
- EXT_writeReady  in  1  unused
- EXT_writeID  out  19  tied 0
- EXT_writeCustomField  out  16  tied 0
- EXT_doneProcessing  out  1  one-cycle end-of-frame pulse
- EXT_status  out  32  [2:0] = state, [31:3] = 0
- o_inside_count  out  32  inside points in the last completed frame
- o_min_x/o_min_y/o_min_z  out  16 each  signed minima
- o_max_x/o_max_y/o_max_z  out  16 each  signed maxima
- o_sum_x/o_sum_y/o_sum_z  out  SUM_W each  signed sums
- o_centroid_x/y/z  out  16 each  signed centroid (optional feature)

Behaviour:
- Reset (i_SYSTEM_rst low, asynchronous): state = RESET (3'b000); all outputs, point counter and accumulators = 0; min accumulators = 16'sh7FFF; max accumulators = 16'sh8000.
- Reset released: RESET → IDLE on the next clock.
- State encodings: IDLE 3'b001, READ_POINT 3'b010, ACCUMULATE 3'b011, DONE_PROCESSING 3'b101, DIVIDE 3'b110, ERROR 3'b111.
- IDLE:
  - EXT_enable && counter < EXT_PCSize → READ_POINT.
  - EXT_enable && counter ≥ EXT_PCSize → DONE_PROCESSING.
  - Otherwise hold.
- READ_POINT:
  - EXT_readReady = 1; EXT_readID = counter.
  - On EXT_readReady && EXT_readValid: capture the point and label into registers, counter += 1, drop EXT_readReady, → ACCUMULATE.
- ACCUMULATE (1 cycle):
  - If captured label == LABEL_INSIDE: count += 1; min/max updated with signed compare; sums += sign-extended coordinate.
  - → IDLE.
  - Per-point latency is handshake + 2 cycles.
- DONE_PROCESSING → DIVIDE if the feature is enabled, else:
  - Copy accumulators to o_* outputs. If count == 0, the min/max outputs are 0, not the sentinels.
  - Pulse EXT_doneProcessing for exactly 1 cycle.
  - Clear the counter and accumulators to their reset values.
  - → IDLE.
- Back-to-back frames: with EXT_enable held and EXT_PCSize > 0, the next frame starts immediately. With EXT_PCSize == 0, the done pulse repeats every 2 cycles and all outputs are 0.
- Error:
  - In any state other than IDLE/RESET, if counter > EXT_PCSize (e.g. PCSize shrinks mid-frame) → ERROR.
  - ERROR is sticky until reset; EXT_readReady = 0; o_* outputs keep their last published values.
- o_* outputs change only in the DONE_PROCESSING publish cycle; they are stable between frames.
- Reset mid-frame: everything clears immediately; no done pulse is generated.

Optional Feature:
- Macro: INSIDE_STATS_CENTROID_EN.
- When defined:
  - DONE_PROCESSING → DIVIDE.
  - DIVIDE runs a sequential restoring divider, 1 quotient bit/cycle, 3 axes back-to-back, SUM_W cycles per axis.
  - Quotient is truncated toward zero and saturated to 16-bit signed; division is on magnitudes and the sign is restored.
  - count == 0 gives centroid 0.
  - Publish and the done pulse occur on DIVIDE exit.
- When undefined: no DIVIDE state; o_centroid_* are tied 0; done latency from entering DONE_PROCESSING is 1 cycle.

Test Plan:
- PCSize=4; points (10,−5,3) L2, (−20,7,0) L1, (4,12,−8) L2, (−1,−1,−1) L2; readValid=1 → count 3, min (−1,−5,−8), max (10,12,3), sums (13,6,−6), one done pulse; centroid (4,2,−2) with the feature on.
- PCSize=3, all labels 1 → count 0, all min/max/sums/centroid 0, done pulse.
- PCSize=0, enable held → done pulses every 2 cycles, EXT_readReady never asserts, status toggles 001/101.
- readValid held low 20 cycles during READ_POINT → readReady stays 1, readID constant, no accumulation, then completes normally.
- PCSize 8 → 2 after 3 points read → status 3'b111 and sticky; readReady 0; outputs unchanged until reset.
- Reset asserted in ACCUMULATE of frame 1 → status 000 asynchronously, outputs 0; a fresh frame gives correct stats with no carry-over.

Source files
------------

// File: rtl/inside_point_stats.sv
// inside_point_stats: read-only extension stage after the distance filter.
// Walks every point of the frame, keeps count / signed bounding box / sums of
// the points labelled inside, and publishes them with a one-cycle done pulse.
// Optional centroid divider: define INSIDE_STATS_CENTROID_EN.
module inside_point_stats #(
  parameter logic [15:0] LABEL_INSIDE = 16'd2,
  parameter int          SUM_W        = 36
) (
  input  logic                    i_SYSTEM_clk,
  input  logic                    i_SYSTEM_rst,
  input  logic                    EXT_enable,
  input  logic [18:0]             EXT_PCSize,
  output logic                    EXT_readReady,
  input  logic                    EXT_readValid,
  output logic [18:0]             EXT_readID,
  input  logic [15:0]             EXT_readCustomField,
  input  logic [15:0]             EXT_pointX,
  input  logic [15:0]             EXT_pointY,
  input  logic [15:0]             EXT_pointZ,
  output logic                    EXT_writeValid,
  input  logic                    EXT_writeReady,
  output logic [18:0]             EXT_writeID,
  output logic [15:0]             EXT_writeCustomField,
  output logic                    EXT_doneProcessing,
  output logic [31:0]             EXT_status,
  output logic [31:0]             o_inside_count,
  output logic signed [15:0]      o_min_x,
  output logic signed [15:0]      o_min_y,
  output logic signed [15:0]      o_min_z,
  output logic signed [15:0]      o_max_x,
  output logic signed [15:0]      o_max_y,
  output logic signed [15:0]      o_max_z,
  output logic signed [SUM_W-1:0] o_sum_x,
  output logic signed [SUM_W-1:0] o_sum_y,
  output logic signed [SUM_W-1:0] o_sum_z,
  output logic signed [15:0]      o_centroid_x,
  output logic signed [15:0]      o_centroid_y,
  output logic signed [15:0]      o_centroid_z
);
  localparam logic [2:0] S_RESET = 3'b000;
  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_READ  = 3'b010;
  localparam logic [2:0] S_ACC   = 3'b011;
  localparam logic [2:0] S_DONE  = 3'b101;
  localparam logic [2:0] S_ERROR = 3'b111;
  localparam logic signed [15:0] MIN_INIT = 16'sh7FFF;
  localparam logic signed [15:0] MAX_INIT = 16'sh8000;

  logic [2:0]               state;
  logic [19:0]              cnt;      // one extra bit so overrun is visible
  logic signed [15:0]       cap_x, cap_y, cap_z;
  logic [15:0]              cap_lab;
  logic [31:0]              acc_n;
  logic signed [15:0]       mn_x, mn_y, mn_z, mx_x, mx_y, mx_z;
  logic signed [SUM_W-1:0]  sm_x, sm_y, sm_z;
  logic                     over;
  logic                     publish;
  logic                     unused;

  assign over                 = cnt > {1'b0, EXT_PCSize};
  assign EXT_readReady        = (state == S_READ);
  assign EXT_readID           = cnt[18:0];
  assign EXT_writeValid       = 1'b0;
  assign EXT_writeID          = '0;
  assign EXT_writeCustomField = '0;
  assign EXT_status           = {29'd0, state};
  assign unused               = EXT_writeReady;

`ifdef INSIDE_STATS_CENTROID_EN
  localparam logic [2:0] S_DIVIDE = 3'b110;
  localparam int         BW       = $clog2(SUM_W + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SUM_W - 1);

  logic [1:0]              div_axis;
  logic [BW-1:0]           div_bit;
  logic [SUM_W-1:0]        div_dvd, div_rem;
  logic [SUM_W-2:0]        div_q;
  logic                    div_neg;
  logic [SUM_W:0]          rem_sh, dvs;
  logic                    ge;
  logic [SUM_W-1:0]        q_nx;
  logic signed [15:0]      res, cen_x, cen_y;
  logic [1:0]              ld_axis;
  logic signed [SUM_W-1:0] ld_sum;

  function automatic logic signed [15:0] sat16(input logic [SUM_W-1:0] q, input logic neg);
    if (!neg) return (q > SUM_W'(32767)) ? 16'sh7FFF : q[15:0];
    else      return (q > SUM_W'(32768)) ? 16'sh8000 : 16'(~q[15:0] + 16'd1);
  endfunction

  assign dvs     = {1'b0, SUM_W'(acc_n)};
  assign rem_sh  = {1'b0, div_rem[SUM_W-2:0], div_dvd[SUM_W-1]} | {div_rem[SUM_W-1], {SUM_W{1'b0}}};
  assign ge      = rem_sh >= dvs;
  assign q_nx    = {div_q, ge};
  assign res     = (acc_n == 32'd0) ? 16'sd0 : sat16(q_nx, div_neg);
  assign publish = (state == S_DIVIDE) && !over && (div_bit == BIT_LAST) && (div_axis == 2'd2);

  // select which axis sum feeds the divider on the next load
  always_comb begin
    ld_axis = (state == S_DONE) ? 2'd0 : div_axis + 2'd1;
    case (ld_axis)
      2'd0:    ld_sum = sm_x;
      2'd1:    ld_sum = sm_y;
      default: ld_sum = sm_z;
    endcase
  end

  // restoring divider on magnitudes, one quotient bit per cycle, axes in turn
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      div_axis <= '0; div_bit <= '0; div_dvd <= '0; div_rem <= '0;
      div_q <= '0; div_neg <= 1'b0; cen_x <= '0; cen_y <= '0;
    end else if (state == S_DONE && !over) begin
      div_axis <= 2'd0; div_bit <= '0; div_rem <= '0; div_q <= '0;
      div_neg  <= ld_sum[SUM_W-1];
      div_dvd  <= ld_sum[SUM_W-1] ? $unsigned(-ld_sum) : $unsigned(ld_sum);
    end else if (state == S_DIVIDE && !over) begin
      div_rem <= SUM_W'(ge ? rem_sh - dvs : rem_sh);
      div_dvd <= div_dvd << 1;
      div_q   <= q_nx[SUM_W-2:0];
      div_bit <= div_bit + 1'b1;
      if (div_bit == BIT_LAST) begin
        if (div_axis == 2'd0) cen_x <= res;
        if (div_axis == 2'd1) cen_y <= res;
        if (div_axis != 2'd2) begin
          div_axis <= div_axis + 2'd1; div_bit <= '0; div_rem <= '0; div_q <= '0;
          div_neg  <= ld_sum[SUM_W-1];
          div_dvd  <= ld_sum[SUM_W-1] ? $unsigned(-ld_sum) : $unsigned(ld_sum);
        end
      end
    end
  end
`else
  assign publish      = (state == S_DONE) && !over;
  assign o_centroid_x = '0;
  assign o_centroid_y = '0;
  assign o_centroid_z = '0;
`endif

  // frame sequencing, point capture and inside-point accumulation
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      state <= S_RESET; cnt <= '0;
      cap_x <= '0; cap_y <= '0; cap_z <= '0; cap_lab <= '0;
      acc_n <= '0; sm_x <= '0; sm_y <= '0; sm_z <= '0;
      mn_x <= MIN_INIT; mn_y <= MIN_INIT; mn_z <= MIN_INIT;
      mx_x <= MAX_INIT; mx_y <= MAX_INIT; mx_z <= MAX_INIT;
    end else begin
      case (state)
        S_RESET: state <= S_IDLE;
        S_IDLE: if (EXT_enable) state <= (cnt < {1'b0, EXT_PCSize}) ? S_READ : S_DONE;
        S_READ:
          if (over) state <= S_ERROR;
          else if (EXT_readValid) begin
            cap_x <= EXT_pointX; cap_y <= EXT_pointY; cap_z <= EXT_pointZ;
            cap_lab <= EXT_readCustomField;
            cnt <= cnt + 20'd1;
            state <= S_ACC;
          end
        S_ACC:
          if (over) state <= S_ERROR;
          else begin
            if (cap_lab == LABEL_INSIDE) begin
              acc_n <= acc_n + 32'd1;
              if (cap_x < mn_x) mn_x <= cap_x;
              if (cap_y < mn_y) mn_y <= cap_y;
              if (cap_z < mn_z) mn_z <= cap_z;
              if (cap_x > mx_x) mx_x <= cap_x;
              if (cap_y > mx_y) mx_y <= cap_y;
              if (cap_z > mx_z) mx_z <= cap_z;
              sm_x <= sm_x + {{(SUM_W-16){cap_x[15]}}, cap_x};
              sm_y <= sm_y + {{(SUM_W-16){cap_y[15]}}, cap_y};
              sm_z <= sm_z + {{(SUM_W-16){cap_z[15]}}, cap_z};
            end
            state <= S_IDLE;
          end
`ifdef INSIDE_STATS_CENTROID_EN
        S_DONE:   state <= over ? S_ERROR : S_DIVIDE;
        S_DIVIDE: if (over) state <= S_ERROR; else if (publish) state <= S_IDLE;
`else
        S_DONE:   state <= over ? S_ERROR : S_IDLE;
`endif
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
      // results are being published this cycle: start the next frame clean
      if (publish) begin
        cnt <= '0; acc_n <= '0; sm_x <= '0; sm_y <= '0; sm_z <= '0;
        mn_x <= MIN_INIT; mn_y <= MIN_INIT; mn_z <= MIN_INIT;
        mx_x <= MAX_INIT; mx_y <= MAX_INIT; mx_z <= MAX_INIT;
      end
    end
  end

  // published results and done pulse; empty frames report a zero box
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      EXT_doneProcessing <= 1'b0; o_inside_count <= '0;
      o_min_x <= '0; o_min_y <= '0; o_min_z <= '0;
      o_max_x <= '0; o_max_y <= '0; o_max_z <= '0;
      o_sum_x <= '0; o_sum_y <= '0; o_sum_z <= '0;
`ifdef INSIDE_STATS_CENTROID_EN
      o_centroid_x <= '0; o_centroid_y <= '0; o_centroid_z <= '0;
`endif
    end else begin
      EXT_doneProcessing <= publish;
      if (publish) begin
        o_inside_count <= acc_n;
        o_min_x <= (acc_n == 32'd0) ? 16'sd0 : mn_x;
        o_min_y <= (acc_n == 32'd0) ? 16'sd0 : mn_y;
        o_min_z <= (acc_n == 32'd0) ? 16'sd0 : mn_z;
        o_max_x <= (acc_n == 32'd0) ? 16'sd0 : mx_x;
        o_max_y <= (acc_n == 32'd0) ? 16'sd0 : mx_y;
        o_max_z <= (acc_n == 32'd0) ? 16'sd0 : mx_z;
        o_sum_x <= sm_x; o_sum_y <= sm_y; o_sum_z <= sm_z;
`ifdef INSIDE_STATS_CENTROID_EN
        o_centroid_x <= cen_x; o_centroid_y <= cen_y; o_centroid_z <= res;
`endif
      end
    end
  end
endmodule

// File: tb/tb_inside_point_stats.sv
// Self-checking bench for inside_point_stats: a reference model computes the
// expected frame statistics when a frame is set up and queues them; a monitor
// pops and compares on every done pulse.
module tb_inside_point_stats;
  localparam int SUM_W = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic en = 1'b0, rv = 1'b1;
  logic [18:0] pcs = '0;
  logic rr, done, wv;
  logic [18:0] rid, wid;
  logic [15:0] lab_in, px_in, py_in, pz_in, wcf;
  logic [31:0] status, o_cnt;
  logic signed [15:0] mnx, mny, mnz, mxx, mxy, mxz, cx, cy, cz;
  logic signed [SUM_W-1:0] sx, sy, sz;

  inside_point_stats #(.LABEL_INSIDE(16'd2), .SUM_W(SUM_W)) dut (
    .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst_n), .EXT_enable(en), .EXT_PCSize(pcs),
    .EXT_readReady(rr), .EXT_readValid(rv), .EXT_readID(rid),
    .EXT_readCustomField(lab_in), .EXT_pointX(px_in), .EXT_pointY(py_in), .EXT_pointZ(pz_in),
    .EXT_writeValid(wv), .EXT_writeReady(1'b0), .EXT_writeID(wid), .EXT_writeCustomField(wcf),
    .EXT_doneProcessing(done), .EXT_status(status), .o_inside_count(o_cnt),
    .o_min_x(mnx), .o_min_y(mny), .o_min_z(mnz), .o_max_x(mxx), .o_max_y(mxy), .o_max_z(mxz),
    .o_sum_x(sx), .o_sum_y(sy), .o_sum_z(sz),
    .o_centroid_x(cx), .o_centroid_y(cy), .o_centroid_z(cz));

  int px[16], py[16], pz[16], lb[16];
  logic [3:0] idx;
  // point memory answering the stage's read address
  always_comb begin
    idx    = rid[3:0];
    px_in  = 16'(px[idx]);
    py_in  = 16'(py[idx]);
    pz_in  = 16'(pz[idx]);
    lab_in = 16'(lb[idx]);
  end

  int n_tests = 0, n_fail = 0;
  task automatic chk(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint cnt, mnx, mny, mnz, mxx, mxy, mxz, sx, sy, sz, cx, cy, cz;
  } exp_t;
  exp_t sb[$];
  exp_t last_e;

  function automatic longint cen(longint s, longint c);
    longint q;
    if (c == 0) return 0;
    q = s / c;
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return q;
  endfunction

  task automatic expect_frame(int n);
    exp_t e;
    e.cnt = 0; e.sx = 0; e.sy = 0; e.sz = 0;
    e.mnx = 32767; e.mny = 32767; e.mnz = 32767;
    e.mxx = -32768; e.mxy = -32768; e.mxz = -32768;
    for (int i = 0; i < n; i++) if (lb[i] == 2) begin
      e.cnt++;
      e.sx += px[i]; e.sy += py[i]; e.sz += pz[i];
      if (px[i] < e.mnx) e.mnx = px[i];
      if (py[i] < e.mny) e.mny = py[i];
      if (pz[i] < e.mnz) e.mnz = pz[i];
      if (px[i] > e.mxx) e.mxx = px[i];
      if (py[i] > e.mxy) e.mxy = py[i];
      if (pz[i] > e.mxz) e.mxz = pz[i];
    end
    if (e.cnt == 0) begin
      e.mnx = 0; e.mny = 0; e.mnz = 0; e.mxx = 0; e.mxy = 0; e.mxz = 0;
    end
`ifdef INSIDE_STATS_CENTROID_EN
    e.cx = cen(e.sx, e.cnt); e.cy = cen(e.sy, e.cnt); e.cz = cen(e.sz, e.cnt);
`else
    e.cx = 0; e.cy = 0; e.cz = 0;
`endif
    sb.push_back(e);
    last_e = e;
  endtask

  // scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("count", o_cnt, e.cnt);
        chk("min_x", mnx, e.mnx); chk("min_y", mny, e.mny); chk("min_z", mnz, e.mnz);
        chk("max_x", mxx, e.mxx); chk("max_y", mxy, e.mxy); chk("max_z", mxz, e.mxz);
        chk("sum_x", sx, e.sx); chk("sum_y", sy, e.sy); chk("sum_z", sz, e.sz);
        chk("cen_x", cx, e.cx); chk("cen_y", cy, e.cy); chk("cen_z", cz, e.cz);
      end
    end
  end

  task automatic run_frame(int n, int budget);
    bit got = 0;
    int c = 0;
    pcs = 19'(n);
    en  = 1'b1;
    while (!got && c < budget) begin
      @(negedge clk);
      c++;
      if (done) got = 1;
    end
    en = 1'b0;
    chk("frame_done", got, 1);
  endtask

  task automatic set_pt(int i, int x, int y, int z, int l);
    px[i] = x; py[i] = y; pz[i] = z; lb[i] = l;
  endtask

  task automatic load_frame_a();
    set_pt(0, 10, -5, 3, 2);
    set_pt(1, -20, 7, 0, 1);
    set_pt(2, 4, 12, -8, 2);
    set_pt(3, -1, -1, -1, 2);
  endtask

  initial begin
    int c, pulses, last_c, acc_seen;
    bit flag_rr, flag_st, flag_gap, flag_id;
    for (int i = 0; i < 16; i++) set_pt(i, 0, 0, 0, 1);

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_status", status, 0); chk("rst_count", o_cnt, 0);
    chk("rst_min_x", mnx, 0); chk("rst_max_y", mxy, 0); chk("rst_sum_z", sz, 0);
    chk("rst_rr", rr, 0); chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", status, 1);

    // mixed labels
    load_frame_a();
    expect_frame(4);
    run_frame(4, 2000);

    // no inside points
    set_pt(0, 5, 6, 7, 1); set_pt(1, -9, 3, 2, 1); set_pt(2, 100, -100, 1, 1);
    expect_frame(3);
    run_frame(3, 2000);

    // empty frames back to back
    for (int i = 0; i < 10; i++) expect_frame(0);
    pcs = '0; en = 1'b1;
    c = 0; pulses = 0; last_c = 0; flag_rr = 0; flag_st = 0; flag_gap = 0;
    while (pulses < 10 && c < 5000) begin
      @(negedge clk);
      c++;
      if (rr) flag_rr = 1;
      if (status[2:0] == 3'b010 || status[2:0] == 3'b011) flag_st = 1;
      if (done) begin
        if (pulses > 0 && c - last_c != 2) flag_gap = 1;
        pulses++; last_c = c;
      end
    end
    en = 1'b0;
    chk("zero_pulses", pulses, 10);
    chk("zero_rr_never", flag_rr, 0);
    chk("zero_no_read_state", flag_st, 0);
`ifndef INSIDE_STATS_CENTROID_EN
    chk("zero_pulse_gap", flag_gap, 0);
`endif

    // readValid stall
    set_pt(0, 100, -200, 300, 2); set_pt(1, -7, 8, -9, 2);
    expect_frame(2);
    rv = 1'b0; pcs = 19'd2; en = 1'b1;
    c = 0;
    while (!rr && c < 100) begin @(negedge clk); c++; end
    chk("stall_rr_up", rr, 1);
    flag_rr = 0; flag_id = 0; flag_st = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rr) flag_rr = 1;
      if (rid != 0) flag_id = 1;
      if (status != 2) flag_st = 1;
    end
    chk("stall_rr_held", flag_rr, 0);
    chk("stall_id_const", flag_id, 0);
    chk("stall_state", flag_st, 0);
    rv = 1'b1;
    run_frame(2, 2000);
    @(negedge clk);

    // PCSize shrinks mid-frame
    for (int i = 0; i < 8; i++) set_pt(i, i * 3 - 7, 50 - i, i, 2);
    pcs = 19'd8; en = 1'b1;
    c = 0; acc_seen = 0;
    while (acc_seen < 3 && c < 200) begin
      @(negedge clk); c++;
      if (status == 3) acc_seen++;
    end
    chk("err_reached_3pts", acc_seen, 3);
    pcs = 19'd2;
    repeat (5) @(negedge clk);
    chk("err_status", status, 7);
    chk("err_rr", rr, 0);
    chk("err_hold_count", o_cnt, last_e.cnt);
    chk("err_hold_sum_x", sx, last_e.sx);
    chk("err_hold_min_y", mny, last_e.mny);
    chk("err_hold_max_z", mxz, last_e.mxz);
    chk("err_hold_cen_x", cx, last_e.cx);
    en = 1'b0; pcs = 19'd8;
    repeat (5) @(negedge clk);
    chk("err_sticky", status, 7);

    // reset during accumulate
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_frame_a();
    pcs = 19'd4; en = 1'b1;
    c = 0;
    while (status != 3 && c < 200) begin @(negedge clk); c++; end
    chk("mid_reached_acc", status, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_status", status, 0);
    chk("mid_rst_count", o_cnt, 0);
    chk("mid_rst_sum_x", sx, 0);
    chk("mid_rst_done", done, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle", status, 1);

    // fresh random frame, no carry-over
    for (int i = 0; i < 10; i++)
      set_pt(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(1, 2)));
    expect_frame(10);
    run_frame(10, 4000);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
